// File: rtl/du_scan_gen_pkg.sv
// Shared timing constants (800x600@72 defaults) and pipeline control word for the scan generator.
package du_scan_gen_pkg;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 56;
  localparam int DEF_H_SYNC   = 120;
  localparam int DEF_H_BP     = 64;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 37;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 23;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 1040
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 666

  // counters -> raddr -> RAM -> rgb
  localparam int PIPE_STAGES = 3;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic win;
  } scan_ctl_t;

  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction
endpackage

// File: rtl/du_timing_cnt.sv
// Raster counters and raw (undelayed) sync / data-enable decode.
module du_timing_cnt #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic          clk_px,
  input  logic          rst,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          h_wrap,
  output logic          v_wrap,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic          de_raw
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;

  assign h_wrap = (hcnt == HW'(H_TOTAL - 1));
  assign v_wrap = (vcnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk_px) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_wrap) begin
      hcnt <= '0;
      vcnt <= v_wrap ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_comb begin
    hs_raw = (int'(hcnt) >= HS_START && int'(hcnt) < HS_START + H_SYNC) ? HS_POL : !HS_POL;
    vs_raw = (int'(vcnt) >= VS_START && int'(vcnt) < VS_START + V_SYNC) ? VS_POL : !VS_POL;
    de_raw = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
  end
endmodule

// File: rtl/du_scan_gen.sv
// Scan-out generator: integer-upscaled framebuffer window over a raster, with 3-stage aligned outputs.
module du_scan_gen import du_scan_gen_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int IMG_W    = 200,
  parameter int IMG_H    = 150,
  parameter int SCALE_SH = 2,
  parameter int IMG_X0   = 0,
  parameter int IMG_Y0   = 0,
  parameter int RGB_W    = 12,
  parameter int ADDR_W   = 15,
  parameter logic [RGB_W-1:0] BORDER_RGB = 12'h000
) (
  input  logic              clk_px,
  input  logic              rst,
  input  logic [RGB_W-1:0]  rdata,
  output logic [ADDR_W-1:0] raddr,
  output logic [RGB_W-1:0]  rgb,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic              frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_w(H_TOTAL);
  localparam int VW      = cnt_w(V_TOTAL);
  localparam int X_RAW   = IMG_X0 + (IMG_W << SCALE_SH);
  localparam int Y_RAW   = IMG_Y0 + (IMG_H << SCALE_SH);
  // Window clipped to the active area so blanking never generates reads.
  localparam int X_END   = (X_RAW < H_ACTIVE) ? X_RAW : H_ACTIVE;
  localparam int Y_END   = (Y_RAW < V_ACTIVE) ? Y_RAW : V_ACTIVE;
  localparam int SW      = (SCALE_SH > 0) ? SCALE_SH : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'((1 << SCALE_SH) - 1);
  localparam scan_ctl_t CTL_IDLE = '{hs: !HS_POL, vs: !VS_POL, de: 1'b0, fs: 1'b0, win: 1'b0};

  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic              h_wrap, v_wrap, hs_raw, vs_raw, de_raw;
  logic              in_x, in_y;
  logic [ADDR_W-1:0] row_base, col;
  logic [SW-1:0]     sub_line;
  scan_ctl_t         ctl0;
  scan_ctl_t         ctl_pipe [PIPE_STAGES:1];

  du_timing_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .HW(HW), .VW(VW)
  ) u_cnt (
    .clk_px (clk_px),
    .rst    (rst),
    .hcnt   (hcnt),
    .vcnt   (vcnt),
    .h_wrap (h_wrap),
    .v_wrap (v_wrap),
    .hs_raw (hs_raw),
    .vs_raw (vs_raw),
    .de_raw (de_raw)
  );

  always_comb begin
    in_x = (int'(hcnt) >= IMG_X0) && (int'(hcnt) < X_END);
    in_y = (int'(vcnt) >= IMG_Y0) && (int'(vcnt) < Y_END);
    col  = ADDR_W'((int'(hcnt) - IMG_X0) >>> SCALE_SH);
    ctl0 = '{hs: hs_raw, vs: vs_raw, de: de_raw,
             fs: (hcnt == '0) && (vcnt == '0), win: in_x && in_y};
  end

  // row_base steps by one image row after every 2^SCALE_SH window lines.
  always_ff @(posedge clk_px) begin
    if (rst) begin
      row_base <= '0;
      sub_line <= '0;
    end else if (h_wrap) begin
      if (v_wrap) begin
        row_base <= '0;
        sub_line <= '0;
      end else if (in_y) begin
        if (sub_line == SUB_LAST) begin
          sub_line <= '0;
          row_base <= row_base + ADDR_W'(IMG_W);
        end else begin
          sub_line <= sub_line + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_px) begin
    if (rst)
      raddr <= '0;
    else if (ctl0.win)
      raddr <= row_base + col;
  end

  always_ff @(posedge clk_px) begin
    if (rst) begin
      for (int i = 1; i <= PIPE_STAGES; i++) ctl_pipe[i] <= CTL_IDLE;
      rgb <= '0;
    end else begin
      ctl_pipe[1] <= ctl0;
      for (int i = 2; i <= PIPE_STAGES; i++) ctl_pipe[i] <= ctl_pipe[i-1];
      // stage PIPE_STAGES-1 is aligned with the RAM read data
      if (ctl_pipe[PIPE_STAGES-1].win)
        rgb <= rdata;
      else if (ctl_pipe[PIPE_STAGES-1].de)
        rgb <= BORDER_RGB;
      else
        rgb <= '0;
    end
  end

  assign hs          = ctl_pipe[PIPE_STAGES].hs;
  assign vs          = ctl_pipe[PIPE_STAGES].vs;
  assign de          = ctl_pipe[PIPE_STAGES].de;
  assign frame_start = ctl_pipe[PIPE_STAGES].fs;
endmodule
